// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: reset vector, fetch FSM encoding and
// predictor index widths reserved for a later pass-through.
package if_fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
   localparam int          CANCEL_W_DEFAULT = 2;

   localparam int BTB_IDX_W = 9;
   localparam int GHR_W     = 8;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_ERR  = 2'd3
   } fetch_state_e;

   function automatic logic pc_misaligned(input logic [1:0] pc_lo);
      return pc_lo != 2'b00;
   endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction bus between the fetch controller (master) and the
// instruction memory port (slave).
interface if_fetch_ctrl_if;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );

endinterface

// File: rtl/if_fetch_ctrl_cancel_cnt.sv
// Saturating up/down counter of in-flight responses that must be discarded.
// A simultaneous increment and decrement leaves the count unchanged.
module if_fetch_ctrl_cancel_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         full
);

   logic [W-1:0] cnt_reg;
   logic [W-1:0] cnt_next;

   assign full = &cnt_reg;
   assign cnt  = cnt_reg;

   always_comb begin
      cnt_next = cnt_reg;
      if (inc && !dec && !full) begin
         cnt_next = cnt_reg + 1'b1;
      end else if (dec && !inc && (cnt_reg != '0)) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, sequences requests on the instruction
// bus, applies redirect priority and discards responses of cancelled requests.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          CANCEL_W = CANCEL_W_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   if_fetch_ctrl_if.master        ibus,
   input  logic                   btb_hit,
   input  logic [31:0]            btb_target,
   input  logic                   ex_flush,
   input  logic [31:0]            ex_flush_pc,
   input  logic                   br_redirect,
   input  logic [31:0]            br_target,
   input  logic                   pd_stall,
   output logic                   if_valid,
   output logic [31:0]            if_pc,
   output logic [31:0]            if_inst,
   output logic                   if_addr_error,
   output logic                   seg_stall,
   output logic                   seg_refresh
);

   fetch_state_e  state_reg, state_next;
   logic [31:0]   pc_reg, pc_next;
   logic [31:0]   buf_inst_reg, buf_inst_next;
   logic          buf_valid_reg, buf_valid_next;

   logic [CANCEL_W-1:0] cancel_cnt;
   logic          cancel_full;
   logic          cnt_inc, cnt_dec;

   logic          red;
   logic [31:0]   red_target;
   logic [31:0]   seq_pc;
   logic          req_c;
   logic          own_resp;

   assign red        = ex_flush | br_redirect;
   assign red_target = ex_flush ? ex_flush_pc : br_target;
   assign seq_pc     = btb_hit ? btb_target : pc_reg + 32'd4;

   // Responses return in order, so any data_ok while discards are pending
   // belongs to a cancelled request regardless of the current state.
   assign cnt_dec  = ibus.inst_data_ok && (cancel_cnt != '0);
   assign own_resp = ibus.inst_data_ok && (cancel_cnt == '0) && (state_reg == ST_WAIT);

   // A redirect orphans our request if it is still outstanding or is being
   // accepted in this very cycle.
   assign cnt_inc = red && (((state_reg == ST_WAIT) && !own_resp) ||
                            ((state_reg == ST_REQ) && req_c && ibus.inst_addr_ok));

   if_fetch_ctrl_cancel_cnt #(
      .W (CANCEL_W)
   ) u_cancel_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc),
      .dec   (cnt_dec),
      .cnt   (cancel_cnt),
      .full  (cancel_full)
   );

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      buf_inst_next  = buf_inst_reg;
      buf_valid_next = buf_valid_reg;
      req_c          = 1'b0;
      if_valid       = 1'b0;
      if_inst        = 32'd0;
      if_addr_error  = 1'b0;

      case (state_reg)
         ST_REQ: begin
            req_c = !pc_misaligned(pc_reg[1:0]) && !cancel_full;
            if (pc_misaligned(pc_reg[1:0])) begin
               state_next = ST_ERR;
            end else if (req_c && ibus.inst_addr_ok) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (own_resp) begin
               if_valid = 1'b1;
               if_inst  = ibus.inst_rdata;
               if (!pd_stall) begin
                  pc_next    = seq_pc;
                  state_next = ST_REQ;
               end else begin
                  buf_inst_next  = ibus.inst_rdata;
                  buf_valid_next = 1'b1;
                  state_next     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if_valid = buf_valid_reg;
            if_inst  = buf_inst_reg;
            if (!pd_stall) begin
               pc_next        = seq_pc;
               buf_valid_next = 1'b0;
               state_next     = ST_REQ;
            end
         end
         ST_ERR: begin
            if_valid      = 1'b1;
            if_addr_error = 1'b1;
         end
         default: state_next = ST_REQ;
      endcase

      // Redirect wins over everything, including a same-cycle delivery.
      if (red) begin
         state_next     = ST_REQ;
         pc_next        = red_target;
         buf_valid_next = 1'b0;
         if_valid       = 1'b0;
         if_inst        = 32'd0;
         if_addr_error  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_REQ;
         pc_reg        <= RESET_PC;
         buf_inst_reg  <= 32'd0;
         buf_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         buf_inst_reg  <= buf_inst_next;
         buf_valid_reg <= buf_valid_next;
      end
   end

   assign ibus.inst_req  = req_c;
   assign ibus.inst_addr = pc_reg;
   assign if_pc          = pc_reg;
   assign seg_refresh    = red;
   assign seg_stall      = pd_stall | ~if_valid | red;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for the fetch controller: one task per scenario, inputs
// driven 1 ns after the rising edge and outputs checked 1 ns later.
module tb_if_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        btb_hit;
   logic [31:0] btb_target;
   logic        ex_flush;
   logic [31:0] ex_flush_pc;
   logic        br_redirect;
   logic [31:0] br_target;
   logic        pd_stall;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_addr_error;
   logic        seg_stall;
   logic        seg_refresh;

   int errors = 0;
   int checks = 0;

   if_fetch_ctrl_if ibus ();

   if_fetch_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .ibus          (ibus),
      .btb_hit       (btb_hit),
      .btb_target    (btb_target),
      .ex_flush      (ex_flush),
      .ex_flush_pc   (ex_flush_pc),
      .br_redirect   (br_redirect),
      .br_target     (br_target),
      .pd_stall      (pd_stall),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_inst       (if_inst),
      .if_addr_error (if_addr_error),
      .seg_stall     (seg_stall),
      .seg_refresh   (seg_refresh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      ibus.inst_addr_ok = 1'b0;
      ibus.inst_data_ok = 1'b0;
      ibus.inst_rdata   = 32'd0;
      btb_hit           = 1'b0;
      btb_target        = 32'd0;
      ex_flush          = 1'b0;
      ex_flush_pc       = 32'd0;
      br_redirect       = 1'b0;
      br_target         = 32'd0;
      pd_stall          = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      #2;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
      checks++; if (ibus.inst_addr !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc: got %h expected bfc00000", ibus.inst_addr); end
      checks++; if (dut.cancel_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dut.cancel_cnt); end
      checks++; if (seg_refresh !== 1'b0) begin errors++; $display("FAIL reset_refresh: got %b expected 0", seg_refresh); end
      cyc();
      reset = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_basic_fetch();
      ibus.inst_addr_ok = 1'b1;
      #1;
      checks++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC00000) begin errors++; $display("FAIL basic_req: got req=%b addr=%h expected 1 bfc00000", ibus.inst_req, ibus.inst_addr); end
      cyc();
      idle();
      ibus.inst_data_ok = 1'b1;
      ibus.inst_rdata   = 32'h24080001;
      #1;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC00000 || if_inst !== 32'h24080001) begin errors++; $display("FAIL basic_deliver: got v=%b pc=%h inst=%h expected 1 bfc00000 24080001", if_valid, if_pc, if_inst); end
      checks++; if (seg_stall !== 1'b0) begin errors++; $display("FAIL basic_seg_stall: got %b expected 0", seg_stall); end
      cyc();
      idle();
      #1;
      checks++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC00004) begin errors++; $display("FAIL basic_next: got req=%b addr=%h expected 1 bfc00004", ibus.inst_req, ibus.inst_addr); end
      $display("test_basic_fetch done");
   endtask

   task automatic test_btb();
      ibus.inst_addr_ok = 1'b1;
      cyc();
      idle();
      ibus.inst_data_ok = 1'b1;
      ibus.inst_rdata   = 32'h10000004;
      btb_hit           = 1'b1;
      btb_target        = 32'hBFC00100;
      #1;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC00004) begin errors++; $display("FAIL btb_deliver: got v=%b pc=%h expected 1 bfc00004", if_valid, if_pc); end
      cyc();
      idle();
      #1;
      checks++; if (ibus.inst_addr !== 32'hBFC00100) begin errors++; $display("FAIL btb_target: got %h expected bfc00100", ibus.inst_addr); end
      $display("test_btb done");
   endtask

   task automatic test_redirect_wait();
      ibus.inst_addr_ok = 1'b1;
      cyc();
      idle();
      br_redirect = 1'b1;
      br_target   = 32'h80001000;
      #1;
      checks++; if (seg_refresh !== 1'b1 || seg_stall !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_outputs: got refresh=%b stall=%b v=%b expected 1 1 0", seg_refresh, seg_stall, if_valid); end
      cyc();
      idle();
      #1;
      checks++; if (dut.cancel_cnt !== 2'd1) begin errors++; $display("FAIL redir_cnt_inc: got %0d expected 1", dut.cancel_cnt); end
      ibus.inst_data_ok = 1'b1;
      ibus.inst_rdata   = 32'hDEADBEEF;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_drop: got v=%b expected 0", if_valid); end
      checks++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'h80001000) begin errors++; $display("FAIL redir_new_req: got req=%b addr=%h expected 1 80001000", ibus.inst_req, ibus.inst_addr); end
      cyc();
      idle();
      #1;
      checks++; if (dut.cancel_cnt !== 2'd0) begin errors++; $display("FAIL redir_cnt_dec: got %0d expected 0", dut.cancel_cnt); end
      ibus.inst_addr_ok = 1'b1;
      cyc();
      idle();
      ibus.inst_data_ok = 1'b1;
      ibus.inst_rdata   = 32'h11111111;
      #1;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80001000 || if_inst !== 32'h11111111) begin errors++; $display("FAIL redir_served: got v=%b pc=%h inst=%h expected 1 80001000 11111111", if_valid, if_pc, if_inst); end
      cyc();
      idle();
      #1;
      checks++; if (ibus.inst_addr !== 32'h80001004) begin errors++; $display("FAIL redir_after: got %h expected 80001004", ibus.inst_addr); end
      $display("test_redirect_wait done");
   endtask

   task automatic test_flush_priority();
      ex_flush    = 1'b1;
      ex_flush_pc = 32'hBFC00380;
      br_redirect = 1'b1;
      br_target   = 32'h80002000;
      #1;
      checks++; if (seg_refresh !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL flush_refresh: got refresh=%b v=%b expected 1 0", seg_refresh, if_valid); end
      cyc();
      idle();
      #1;
      checks++; if (ibus.inst_addr !== 32'hBFC00380) begin errors++; $display("FAIL flush_pc: got %h expected bfc00380", ibus.inst_addr); end
      checks++; if (dut.cancel_cnt !== 2'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", dut.cancel_cnt); end
      $display("test_flush_priority done");
   endtask

   task automatic test_hold();
      ibus.inst_addr_ok = 1'b1;
      cyc();
      idle();
      ibus.inst_data_ok = 1'b1;
      ibus.inst_rdata   = 32'hA5A5A5A5;
      pd_stall          = 1'b1;
      #1;
      checks++; if (if_valid !== 1'b1 || seg_stall !== 1'b1) begin errors++; $display("FAIL hold_capture: got v=%b stall=%b expected 1 1", if_valid, seg_stall); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         idle();
         pd_stall          = 1'b1;
         ibus.inst_rdata   = 32'h5A5A5A5A;
         #1;
         checks++; if (if_valid !== 1'b1 || if_inst !== 32'hA5A5A5A5 || if_pc !== 32'hBFC00380 || ibus.inst_req !== 1'b0) begin errors++; $display("FAIL hold_stable%0d: got v=%b inst=%h pc=%h req=%b expected 1 a5a5a5a5 bfc00380 0", i, if_valid, if_inst, if_pc, ibus.inst_req); end
      end
      cyc();
      idle();
      #1;
      checks++; if (if_valid !== 1'b1 || seg_stall !== 1'b0 || if_inst !== 32'hA5A5A5A5) begin errors++; $display("FAIL hold_release: got v=%b stall=%b inst=%h expected 1 0 a5a5a5a5", if_valid, seg_stall, if_inst); end
      cyc();
      #1;
      checks++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC00384) begin errors++; $display("FAIL hold_next: got req=%b addr=%h expected 1 bfc00384", ibus.inst_req, ibus.inst_addr); end
      $display("test_hold done");
   endtask

   task automatic test_addr_error();
      br_redirect = 1'b1;
      br_target   = 32'h80000002;
      cyc();
      idle();
      #1;
      checks++; if (ibus.inst_req !== 1'b0 || ibus.inst_addr !== 32'h80000002) begin errors++; $display("FAIL err_no_req: got req=%b addr=%h expected 0 80000002", ibus.inst_req, ibus.inst_addr); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         #1;
         checks++; if (if_valid !== 1'b1 || if_addr_error !== 1'b1 || if_inst !== 32'd0 || if_pc !== 32'h80000002 || ibus.inst_req !== 1'b0) begin errors++; $display("FAIL err_state%0d: got v=%b aerr=%b inst=%h pc=%h req=%b expected 1 1 0 80000002 0", i, if_valid, if_addr_error, if_inst, if_pc, ibus.inst_req); end
      end
      ex_flush    = 1'b1;
      ex_flush_pc = 32'hBFC00000;
      #1;
      checks++; if (if_valid !== 1'b0 || seg_refresh !== 1'b1) begin errors++; $display("FAIL err_flush: got v=%b refresh=%b expected 0 1", if_valid, seg_refresh); end
      cyc();
      idle();
      #1;
      checks++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC00000 || if_addr_error !== 1'b0) begin errors++; $display("FAIL err_recover: got req=%b addr=%h aerr=%b expected 1 bfc00000 0", ibus.inst_req, ibus.inst_addr, if_addr_error); end
      $display("test_addr_error done");
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 3; i++) begin
         ibus.inst_addr_ok = 1'b1;
         br_redirect       = 1'b1;
         br_target         = 32'hBFC00000;
         cyc();
         idle();
      end
      #1;
      checks++; if (dut.cancel_cnt !== 2'd3 || ibus.inst_req !== 1'b0) begin errors++; $display("FAIL sat_full: got cnt=%0d req=%b expected 3 0", dut.cancel_cnt, ibus.inst_req); end
      ibus.inst_addr_ok = 1'b1;
      br_redirect       = 1'b1;
      br_target         = 32'hBFC00000;
      cyc();
      idle();
      #1;
      checks++; if (dut.cancel_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold: got cnt=%0d expected 3", dut.cancel_cnt); end
      ibus.inst_data_ok = 1'b1;
      cyc();
      idle();
      #1;
      checks++; if (dut.cancel_cnt !== 2'd2 || ibus.inst_req !== 1'b1) begin errors++; $display("FAIL sat_drain: got cnt=%0d req=%b expected 2 1", dut.cancel_cnt, ibus.inst_req); end
      reset = 1'b1;
      #1;
      checks++; if (dut.cancel_cnt !== 2'd0) begin errors++; $display("FAIL sat_reset: got cnt=%0d expected 0", dut.cancel_cnt); end
      cyc();
      reset = 1'b0;
      $display("test_saturate done");
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_btb();
      test_redirect_wait();
      test_flush_priority();
      test_hold();
      test_addr_error();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch-stage controller that owns the PC register and sequences instruction requests over the SRAM-like instruction bus.
It applies redirect priority (exception flush > branch mispredict > BTB prediction > PC+4) and drops responses to cancelled requests.
It drives the IF outputs plus the stall/refresh controls consumed by the IF->PD pipeline register.
It sits between the branch predictor/backend redirect sources and the IF/PD segment.

Parameters:
RESET_PC, 32'hBFC00000, PC loaded on reset
CANCEL_W, 2, width of the cancelled-response counter (max 2^CANCEL_W-1 pending discards)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_req  out  1  instruction request valid
inst_addr  out  32  request address (= pc)
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  response data valid this cycle
inst_rdata  in  32  response data
btb_hit  in  1  prediction for current pc taken
btb_target  in  32  predicted target
ex_flush  in  1  exception/ERET flush, highest priority
ex_flush_pc  in  32  flush target
br_redirect  in  1  branch mispredict redirect
br_target  in  32  corrected target
pd_stall  in  1  downstream (PD) cannot accept
if_valid  out  1  IF output valid this cycle
if_pc  out  32  pc of delivered instruction
if_inst  out  32  delivered instruction
if_addr_error  out  1  delivered pc misaligned
seg_stall  out  1  stall to IF/PD register
seg_refresh  out  1  refresh to IF/PD register

Behaviour:
- Reset: pc=RESET_PC, state=REQ, cancel_cnt=0, buf_valid=0. All registered outputs are 0.
- States:
  - REQ: inst_req = (pc[1:0]==0) && cancel_cnt != max. If pc[1:0]!=0, no request; go to ERR. On inst_addr_ok, go to WAIT.
  - WAIT: awaiting data. A data_ok with cancel_cnt>0 is a cancelled response: decrement cancel_cnt and stay in WAIT. Otherwise data_ok delivers: if_valid=1, if_inst=inst_rdata. If pd_stall=0, pc<=next and go to REQ. If pd_stall=1, capture into buffer and go to HOLD.
  - HOLD: if_valid=1 from buffer. On pd_stall=0, pc<=next and go to REQ.
  - ERR: if_valid=1, if_addr_error=1, if_inst=0. Hold until a redirect arrives.
- next = btb_hit ? btb_target : pc+32'd4. btb_hit is sampled in the delivery cycle; the 32-bit add wraps modulo 2^32.
- Redirect: red = ex_flush | br_redirect; target = ex_flush ? ex_flush_pc : br_target.
  - On red, in any state: pc<=target, state<=REQ, buf_valid<=0.
  - If the state is WAIT and data_ok is not arriving the same cycle, cancel_cnt++.
  - If a request is accepted in the same cycle as red (REQ && inst_addr_ok), cancel_cnt++.
  - Redirect overrides delivery in the same cycle: if_valid=0.
- Counter: cancel_cnt never exceeds its max. While it is at max, inst_req is held low.
- seg_refresh = red (combinational).
- seg_stall = pd_stall | ~if_valid | red. The refresh path wins inside the segment.
- Latency: with addr_ok in the request cycle and data_ok one cycle later, one instruction per 2 cycles. Back-to-back pipelining is out of scope.
- Reset asserted mid-transaction clears cancel_cnt. The bus is reset with the core, so no orphan responses need tracking.

Decomposition:
- Shared header: RESET_PC default, fetch-state encoding (REQ/WAIT/HOLD/ERR), and the existing BTB/GHR width macros, for a later pass-through of predictor index fields.
- One natural sub-module: if_cancel_cnt, a saturating up/down counter with simultaneous inc/dec giving a net 0 change.
- FSM, PC register and output buffer stay in the top level.

Test Plan:
- Reset release, addr_ok same cycle, data_ok next cycle with rdata=32'h24080001 -> inst_addr=BFC00000; if_valid=1, if_pc=BFC00000; then inst_addr=BFC00004.
- btb_hit=1 with btb_target=BFC00100 on delivery -> next inst_addr=BFC00100.
- br_redirect to 80001000 while in WAIT, then stale data_ok next cycle -> stale data dropped (if_valid=0), cancel_cnt 1->0, new request to 80001000 served normally.
- ex_flush=1 (ex_flush_pc=BFC00380) and br_redirect=1 in the same cycle -> pc=BFC00380, seg_refresh=1.
- pd_stall=1 for 3 cycles when data_ok arrives -> HOLD, if_valid and if_inst held stable, no inst_req; pd_stall drops -> REQ for pc+4.
- Redirect to 80000002 -> no inst_req, if_valid=1 with if_addr_error=1 until the next ex_flush.
